// File: rtl/register_readback_tx.sv
// register_readback_tx
// Shadows every write on the shared register bus and, when the host asks,
// sends the shadow contents as a byte frame on the Simple Interface:
//   HEADER_BYTE, then {index, data[15:8], data[7:0]} for each register.
// Optional build macro: REG_READBACK_CHECKSUM_EN appends an XOR checksum
// byte covering every earlier byte of the frame, header included.
module register_readback_tx #(
  parameter int                         TX_DATA_WIDTH  = 8,
  parameter int                         REG_ADDR_WIDTH = 8,
  parameter int                         REG_DATA_WIDTH = 16,
  parameter int                         NUM_REGS       = 16,
  parameter logic [TX_DATA_WIDTH-1:0]   HEADER_BYTE    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      rqst_regs,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_LIMIT = REG_ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    ADDR,
    DATA_H,
    DATA_L
`ifdef REG_READBACK_CHECKSUM_EN
    , CHECKSUM
`endif
  } state_t;

  state_t                    state;
  logic [REG_DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [REG_DATA_WIDTH-1:0] hold;
  logic [IDX_W-1:0]          index;
  logic [IDX_W-1:0]          next_index;
  logic                      xfer;
  logic                      shadow_we;
`ifdef REG_READBACK_CHECKSUM_EN
  logic [TX_DATA_WIDTH-1:0]  csum_acc;
`endif

  assign xfer       = tx_rdy & tx_ack;
  assign next_index = index + 1'b1;
  assign shadow_we  = register_rdy && (register_addr < ADDR_LIMIT);

  // Shadow file: capture every in-range bus write, regardless of frame state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow[register_addr[IDX_W-1:0]] <= register_data;
    end
  end

  // Frame sequencer: every output is registered and loaded with the byte
  // that should be on the bus in the cycle after the transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_rdy   <= 1'b0;
      tx_eof   <= 1'b0;
      busy     <= 1'b0;
      index    <= '0;
      hold     <= '0;
`ifdef REG_READBACK_CHECKSUM_EN
      csum_acc <= '0;
`endif
    end else begin
`ifdef REG_READBACK_CHECKSUM_EN
      if (xfer) begin
        csum_acc <= csum_acc ^ tx_data;
      end
`endif
      case (state)
        IDLE: begin
          if (rqst_regs) begin
            state    <= HEADER;
            tx_data  <= HEADER_BYTE;
            tx_rdy   <= 1'b1;
            tx_eof   <= 1'b0;
            busy     <= 1'b1;
            index    <= '0;
`ifdef REG_READBACK_CHECKSUM_EN
            csum_acc <= '0;
`endif
          end
        end
        HEADER: begin
          if (xfer) begin
            state   <= ADDR;
            tx_data <= TX_DATA_WIDTH'(index);
          end
        end
        ADDR: begin
          // The shadow read sees the pre-edge value, so a same-cycle
          // write to this address is deliberately left out of the frame
          if (xfer) begin
            state   <= DATA_H;
            hold    <= shadow[index];
            tx_data <= shadow[index][REG_DATA_WIDTH-1:TX_DATA_WIDTH];
          end
        end
        DATA_H: begin
          if (xfer) begin
            state   <= DATA_L;
            tx_data <= hold[TX_DATA_WIDTH-1:0];
`ifdef REG_READBACK_CHECKSUM_EN
            tx_eof  <= 1'b0;
`else
            tx_eof  <= (index == LAST_IDX);
`endif
          end
        end
        DATA_L: begin
          if (xfer) begin
            if (index < LAST_IDX) begin
              state   <= ADDR;
              index   <= next_index;
              tx_data <= TX_DATA_WIDTH'(next_index);
              tx_eof  <= 1'b0;
            end else begin
`ifdef REG_READBACK_CHECKSUM_EN
              state   <= CHECKSUM;
              tx_data <= csum_acc ^ tx_data;
              tx_eof  <= 1'b1;
`else
              state   <= IDLE;
              tx_data <= '0;
              tx_rdy  <= 1'b0;
              tx_eof  <= 1'b0;
              busy    <= 1'b0;
`endif
            end
          end
        end
`ifdef REG_READBACK_CHECKSUM_EN
        CHECKSUM: begin
          if (xfer) begin
            state   <= IDLE;
            tx_data <= '0;
            tx_rdy  <= 1'b0;
            tx_eof  <= 1'b0;
            busy    <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          tx_rdy <= 1'b0;
          tx_eof <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_readback_tx.sv
// tb_register_readback_tx
// Directed bench for register_readback_tx: a per-cycle vector table for
// reset and the start of a frame, then whole-frame sequences compared
// against a shadow model kept by the bench.
module tb_register_readback_tx;

  localparam int NREGS = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        rqst_regs;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mdl [NREGS];

  register_readback_tx dut (
    .clk           (clk),
    .rst           (rst),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .rqst_regs     (rqst_regs),
    .tx_data       (tx_data),
    .tx_rdy        (tx_rdy),
    .tx_eof        (tx_eof),
    .tx_ack        (tx_ack),
    .busy          (busy)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       rqst;
    logic       ack;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_eof;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [12];

  // Single comparison point; every check in the bench goes through here
  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one table row at the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    rqst_regs = v.rqst;
    tx_ack    = v.ack;
    if (v.rst) begin
      for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    end
  endtask

  // Compare one table row just after the rising edge
  task automatic checkOutput(input vec_t v);
    @(posedge clk);
    #1;
    check_eq(v.name, 32'({tx_rdy, tx_eof, busy, tx_data}),
             32'({v.exp_rdy, v.exp_eof, v.exp_busy, v.exp_data}));
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    @(negedge clk);
    register_rdy  = 1'b0;
    if (a < NREGS) mdl[a[3:0]] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
  endtask

  // Request a frame and check every byte against the model.
  //   immediate : issue the request at the current falling edge
  //   rand_ack  : randomise tx_ack instead of holding it high
  //   stall_at  : byte index where ack is held low for 3 cycles while
  //               address 5 is rewritten to 16'hBEEF
  //   rqst_at   : byte index where a second request is pulsed
  //   abort_at  : byte index where rst is asserted mid-frame
  task automatic run_frame(input string tag, input bit immediate, input bit rand_ack,
                           input int stall_at, input int rqst_at, input int abort_at);
    logic [7:0] exp_q [$];
    logic [7:0] csum;
    logic [7:0] hold_data;
    logic       hold_eof;
    bit         hold_valid = 0;
    bit         rq_done = 0;
    bit         finished = 0;
    bit         a;
    int         idx = 0;
    int         stall_cnt = 0;

    exp_q.push_back(8'hA5);
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back(8'(i));
      exp_q.push_back(mdl[i][15:8]);
      exp_q.push_back(mdl[i][7:0]);
    end
`ifdef REG_READBACK_CHECKSUM_EN
    csum = '0;
    foreach (exp_q[k]) csum ^= exp_q[k];
    exp_q.push_back(csum);
`else
    csum = '0;
`endif

    if (!immediate) @(negedge clk);
    rqst_regs = 1'b1;
    tx_ack    = 1'b0;
    @(negedge clk);

    for (int cyc = 0; cyc < 1000; cyc++) begin
      register_rdy = 1'b0;
      rqst_regs    = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq({tag, " async reset"}, 32'({tx_rdy, tx_eof, busy, tx_data}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        tx_ack = 1'b0;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        return;
      end
      if (hold_valid) begin
        check_eq($sformatf("%s stable byte%0d", tag, idx), 32'({tx_rdy, tx_eof, tx_data}),
                 32'({1'b1, hold_eof, hold_data}));
        hold_valid = 0;
      end
      if (rqst_at >= 0 && idx == rqst_at && !rq_done) begin
        rqst_regs = 1'b1;
        rq_done   = 1;
      end
      if (tx_rdy) begin
        if (stall_at >= 0 && idx == stall_at && stall_cnt < 3) begin
          a = 1'b0;
          if (stall_cnt == 0) begin
            register_addr = 8'd5;
            register_data = 16'hBEEF;
            register_rdy  = 1'b1;
            mdl[5] = 16'hBEEF;
          end
          stall_cnt++;
        end else if (rand_ack) begin
          a = 1'($urandom_range(0, 1));
        end else begin
          a = 1'b1;
        end
        tx_ack = a;
        if (a) begin
          check_eq($sformatf("%s byte%0d", tag, idx), 32'({tx_eof, tx_data}),
                   32'({(idx == exp_q.size() - 1), exp_q[idx]}));
          idx++;
          if (idx == exp_q.size()) begin
            finished = 1;
            break;
          end
        end else begin
          hold_valid = 1;
          hold_data  = tx_data;
          hold_eof   = tx_eof;
        end
      end else begin
        tx_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end

    if (!finished) begin
      check_eq({tag, " frame timeout"}, 32'(idx), 32'(exp_q.size()));
      return;
    end
    @(negedge clk);
    tx_ack       = 1'b0;
    register_rdy = 1'b0;
    check_eq({tag, " idle after frame"}, 32'({tx_rdy, tx_eof, busy}), 32'(0));
    if (rqst_at >= 0) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check_eq({tag, " no queued frame"}, 32'({tx_rdy, busy}), 32'(0));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    register_addr = '0;
    register_data = '0;
    register_rdy  = 1'b0;
    rqst_regs     = 1'b0;
    tx_ack        = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;

    //          name          rst  rqst ack  rdy  data   eof  busy
    vecs[0]  = '{"reset",      1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{"idle",       1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{"header",     1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[3]  = '{"hdr stall",  1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[4]  = '{"addr0",      1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{"data0 hi",   1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{"data0 lo",   1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{"addr1",      1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[8]  = '{"rqst busy",  1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{"data1 hi",   1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{"mid reset",  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{"ack ignore", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    @(negedge clk);
    rqst_regs = 1'b0;
    tx_ack    = 1'b0;

    $display("[TB] all-zero frame");
    run_frame("zero", 0, 0, -1, -1, -1);

    $display("[TB] writes to addr 3 and out-of-range addr 20");
    write_reg(8'd3, 16'h12C4);
    write_reg(8'd20, 16'hFFFF);
    run_frame("wr3", 0, 0, -1, -1, -1);

    $display("[TB] request in first idle cycle, random ack");
    run_frame("rand", 1, 1, -1, -1, -1);

    $display("[TB] stall at addr 5 high byte while rewriting addr 5");
    run_frame("stall", 0, 1, 17, -1, -1);
    run_frame("after stall", 0, 0, -1, -1, -1);

    $display("[TB] second request mid-frame");
    run_frame("dup rqst", 0, 0, -1, 10, -1);

    $display("[TB] reset at byte 20");
    run_frame("abort", 0, 0, -1, -1, 20);
    run_frame("post abort", 0, 0, -1, -1, -1);

    $display("[TB] only addr 1 written");
    pulse_reset();
    write_reg(8'd1, 16'h00FF);
    run_frame("addr1", 0, 0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
